// File: rtl/tick_serial_tx.sv
// Tick-paced serial transmitter: start bit, DATA_W data bits LSB first,
// optional parity, 1 or 2 stop bits. Line idles high.
//
// state  | meaning
// IDLE   | line high, ready for a word
// ARM    | word latched, waiting for the next tick to align the start bit
// START  | start bit (line low)
// DATA   | data bits, LSB first
// PARITY | parity bit
// STOP   | stop bit period(s), line high
module tick_serial_tx #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, ARM, START, DATA, PARITY, STOP} state_t;

  localparam logic [4:0] LAST_BIT  = 5'(DATA_W - 1);
  localparam logic       LAST_STOP = (STOP_BITS == 2);
  localparam logic       ODD_B     = (PARITY_ODD != 0);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                par_q, par_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic                stop_cnt_q, stop_cnt_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = in_data;
          par_d   = (^in_data) ^ ODD_B;
          state_d = ARM;
        end
      end
      ARM: if (tick) state_d = START;
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_cnt_d = 5'd0;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d    = (PARITY_EN != 0) ? PARITY : STOP;
            stop_cnt_d = 1'b0;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d    = STOP;
          stop_cnt_d = 1'b0;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line and busy follow the state being entered so they are registered
    // without lagging the state by a cycle.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      bit_cnt_q  <= 5'd0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign tx_out   = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_tick_serial_tx.sv
// Directed bench for tick_serial_tx: four instances cover the default frame,
// even/odd parity and two stop bits; ticks arrive every third clock.
module tb_tick_serial_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       tick_en;
  logic [3:0] in_valid;
  logic [7:0] in_data [4];
  logic [3:0] in_ready, tx_out, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // 0: 8N1   1: 8E1   2: 8O1   3: 8N2
  tick_serial_tx #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_base (
    .clk(clk), .rst(rst), .tick(tick), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .tx_out(tx_out[0]), .busy(busy[0]), .done(done[0]));
  tick_serial_tx #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
    .clk(clk), .rst(rst), .tick(tick), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .tx_out(tx_out[1]), .busy(busy[1]), .done(done[1]));
  tick_serial_tx #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst(rst), .tick(tick), .in_valid(in_valid[2]), .in_data(in_data[2]),
    .in_ready(in_ready[2]), .tx_out(tx_out[2]), .busy(busy[2]), .done(done[2]));
  tick_serial_tx #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .rst(rst), .tick(tick), .in_valid(in_valid[3]), .in_data(in_data[3]),
    .in_ready(in_ready[3]), .tx_out(tx_out[3]), .busy(busy[3]), .done(done[3]));

  // Tick on every third clock while enabled.
  initial begin
    int tcnt;
    tick = 1'b0;
    tcnt = 0;
    forever begin
      @(negedge clk);
      if (!tick_en) begin
        tick = 1'b0;
        tcnt = 0;
      end else begin
        tcnt = (tcnt == 2) ? 0 : tcnt + 1;
        tick = (tcnt == 2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input int idx, input logic [7:0] d, output bit tmo);
    int w = 0;
    @(negedge clk);
    in_valid[idx] = 1'b1;
    in_data[idx]  = d;
    while (!in_ready[idx] && w < 100) begin
      @(negedge clk);
      w++;
    end
    tmo = (w >= 100);
    @(negedge clk);
    in_valid[idx] = 1'b0;
  endtask

  // Records one line bit per 3-cycle bit period, starting at the start bit;
  // returns at the negedge following the last bit period (the done cycle).
  task automatic capture(input int idx, input int nbits, output logic [15:0] bits,
                         output bit tmo, output bit unstable, output bit early_done,
                         output bit rdy_hi);
    int w = 0;
    logic s0;
    bits = '0; tmo = 0; unstable = 0; early_done = 0; rdy_hi = 0;
    while (tx_out[idx] !== 1'b0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) begin
      tmo = 1;
      return;
    end
    for (int k = 0; k < nbits; k++) begin
      s0 = tx_out[idx];
      bits[k] = s0;
      for (int j = 0; j < 3; j++) begin
        if (j > 0) @(negedge clk);
        if (tx_out[idx] !== s0) unstable = 1;
        if (done[idx] !== 1'b0) early_done = 1;
        if (in_ready[idx] !== 1'b0) rdy_hi = 1;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 4'hF;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({tx_out, busy, done, in_ready} !== {4'hF, 4'h0, 4'h0, 4'hF}) begin
      n_err++;
      $display("FAIL reset_outputs: got tx=%b busy=%b done=%b rdy=%b required tx=1111 busy=0000 done=0000 rdy=1111",
               tx_out, busy, done, in_ready);
    end
    in_valid = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    tick_en = 1'b1;
    repeat (12) @(negedge clk);
    n_cmp++;
    if ({tx_out, busy, done, in_ready} !== {4'hF, 4'h0, 4'h0, 4'hF}) begin
      n_err++;
      $display("FAIL idle_tick_ignored: got tx=%b busy=%b done=%b rdy=%b required tx=1111 busy=0000 done=0000 rdy=1111",
               tx_out, busy, done, in_ready);
    end
  endtask

  task automatic test_basic();
    bit tmo, uns, ed, rh;
    logic [15:0] bits;
    send(0, 8'hA5, tmo);
    capture(0, 10, bits, tmo, uns, ed, rh);
    n_cmp++;
    // start=0, data 1,0,1,0,0,1,0,1, stop=1 (bit 0 of the vector is first on the line)
    if (bits !== 16'h034A) begin
      n_err++;
      $display("FAIL basic_frame_a5: got %h required 034a", bits);
    end
    n_cmp++;
    if ({tmo, uns, ed, rh} !== 4'b0) begin
      n_err++;
      $display("FAIL basic_frame_flags: got tmo/unstable/early_done/ready=%b required 0000", {tmo, uns, ed, rh});
    end
    n_cmp++;
    if ({done[0], busy[0], in_ready[0]} !== 3'b101) begin
      n_err++;
      $display("FAIL basic_done_cycle: got done/busy/rdy=%b required 101", {done[0], busy[0], in_ready[0]});
    end
    @(negedge clk);
    n_cmp++;
    if ({done[0], busy[0], tx_out[0]} !== 3'b001) begin
      n_err++;
      $display("FAIL basic_after_done: got done/busy/tx=%b required 001", {done[0], busy[0], tx_out[0]});
    end
  endtask

  task automatic test_parity();
    bit tmo, uns, ed, rh;
    logic [15:0] bits;
    send(1, 8'hA5, tmo);
    capture(1, 11, bits, tmo, uns, ed, rh);
    n_cmp++;
    if (bits !== {5'd0, 1'b1, 1'b0, 8'hA5, 1'b0} || {tmo, uns, ed, rh} !== 4'b0) begin
      n_err++;
      $display("FAIL parity_even_a5: got %h flags=%b required %h flags=0000",
               bits, {tmo, uns, ed, rh}, {5'd0, 1'b1, 1'b0, 8'hA5, 1'b0});
    end
    n_cmp++;
    if ({done[1], busy[1]} !== 2'b10) begin
      n_err++;
      $display("FAIL parity_even_done: got done/busy=%b required 10", {done[1], busy[1]});
    end
    send(2, 8'hA5, tmo);
    capture(2, 11, bits, tmo, uns, ed, rh);
    n_cmp++;
    if (bits !== {5'd0, 1'b1, 1'b1, 8'hA5, 1'b0} || {tmo, uns, ed, rh} !== 4'b0) begin
      n_err++;
      $display("FAIL parity_odd_a5: got %h flags=%b required %h flags=0000",
               bits, {tmo, uns, ed, rh}, {5'd0, 1'b1, 1'b1, 8'hA5, 1'b0});
    end
    n_cmp++;
    if ({done[2], busy[2]} !== 2'b10) begin
      n_err++;
      $display("FAIL parity_odd_done: got done/busy=%b required 10", {done[2], busy[2]});
    end
    send(1, 8'h01, tmo);
    capture(1, 11, bits, tmo, uns, ed, rh);
    n_cmp++;
    if (bits !== {5'd0, 1'b1, 1'b1, 8'h01, 1'b0} || {tmo, uns, ed, rh} !== 4'b0) begin
      n_err++;
      $display("FAIL parity_even_01: got %h flags=%b required %h flags=0000",
               bits, {tmo, uns, ed, rh}, {5'd0, 1'b1, 1'b1, 8'h01, 1'b0});
    end
    n_cmp++;
    if (done[1] !== 1'b1) begin
      n_err++;
      $display("FAIL parity_even_01_done: got %b required 1", done[1]);
    end
  endtask

  task automatic test_back_to_back();
    bit tmo, uns, ed, rh;
    logic [15:0] bits;
    int w = 0;
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h3C;
    while (!in_ready[0] && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    in_data[0] = 8'hC3;
    capture(0, 10, bits, tmo, uns, ed, rh);
    n_cmp++;
    if (bits !== {6'd0, 1'b1, 8'h3C, 1'b0} || {tmo, uns, ed, rh} !== 4'b0) begin
      n_err++;
      $display("FAIL b2b_first: got %h flags=%b required %h flags=0000",
               bits, {tmo, uns, ed, rh}, {6'd0, 1'b1, 8'h3C, 1'b0});
    end
    n_cmp++;
    if ({done[0], in_ready[0], tx_out[0]} !== 3'b111) begin
      n_err++;
      $display("FAIL b2b_done_cycle: got done/rdy/tx=%b required 111", {done[0], in_ready[0], tx_out[0]});
    end
    @(negedge clk);
    in_valid[0] = 1'b0;
    n_cmp++;
    if ({done[0], busy[0], in_ready[0], tx_out[0]} !== 4'b0101) begin
      n_err++;
      $display("FAIL b2b_second_accept: got done/busy/rdy/tx=%b required 0101",
               {done[0], busy[0], in_ready[0], tx_out[0]});
    end
    capture(0, 10, bits, tmo, uns, ed, rh);
    n_cmp++;
    if (bits !== {6'd0, 1'b1, 8'hC3, 1'b0} || {tmo, uns, ed, rh} !== 4'b0) begin
      n_err++;
      $display("FAIL b2b_second: got %h flags=%b required %h flags=0000",
               bits, {tmo, uns, ed, rh}, {6'd0, 1'b1, 8'hC3, 1'b0});
    end
    @(negedge clk);
    n_cmp++;
    if ({busy[0], in_ready[0]} !== 2'b01) begin
      n_err++;
      $display("FAIL b2b_idle_after: got busy/rdy=%b required 01", {busy[0], in_ready[0]});
    end
  endtask

  task automatic test_reset_mid_frame();
    bit tmo, uns, ed, rh;
    logic [15:0] bits;
    int w = 0;
    bit saw_done = 0;
    bit saw_low = 0;
    send(0, 8'h00, tmo);
    while (tx_out[0] !== 1'b0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    repeat (16) @(negedge clk);
    n_cmp++;
    if ({tx_out[0], busy[0]} !== 2'b01) begin
      n_err++;
      $display("FAIL midframe_pre: got tx/busy=%b required 01", {tx_out[0], busy[0]});
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({tx_out[0], busy[0], in_ready[0], done[0]} !== 4'b1010) begin
      n_err++;
      $display("FAIL midframe_reset: got tx/busy/rdy/done=%b required 1010",
               {tx_out[0], busy[0], in_ready[0], done[0]});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done[0] !== 1'b0) saw_done = 1;
      if (tx_out[0] !== 1'b1) saw_low = 1;
    end
    n_cmp++;
    if ({saw_done, saw_low} !== 2'b00) begin
      n_err++;
      $display("FAIL midframe_quiet: got done_seen/low_seen=%b required 00", {saw_done, saw_low});
    end
    send(0, 8'h0F, tmo);
    capture(0, 10, bits, tmo, uns, ed, rh);
    n_cmp++;
    if (bits !== {6'd0, 1'b1, 8'h0F, 1'b0} || {tmo, uns, ed, rh} !== 4'b0 || done[0] !== 1'b1) begin
      n_err++;
      $display("FAIL midframe_next_0f: got %h flags=%b done=%b required %h flags=0000 done=1",
               bits, {tmo, uns, ed, rh}, done[0], {6'd0, 1'b1, 8'h0F, 1'b0});
    end
  endtask

  task automatic test_two_stop();
    bit tmo, uns, ed, rh;
    logic [15:0] bits;
    send(3, 8'h00, tmo);
    capture(3, 11, bits, tmo, uns, ed, rh);
    n_cmp++;
    if (bits !== {5'd0, 2'b11, 8'h00, 1'b0} || {tmo, uns, ed, rh} !== 4'b0) begin
      n_err++;
      $display("FAIL stop2_frame: got %h flags=%b required %h flags=0000",
               bits, {tmo, uns, ed, rh}, {5'd0, 2'b11, 8'h00, 1'b0});
    end
    n_cmp++;
    if ({done[3], busy[3]} !== 2'b10) begin
      n_err++;
      $display("FAIL stop2_done: got done/busy=%b required 10", {done[3], busy[3]});
    end
  endtask

  task automatic test_tick_stall();
    bit tmo, uns, ed, rh;
    logic [15:0] bits;
    bit bad = 0;
    tick_en = 1'b0;
    send(0, 8'h81, tmo);
    repeat (50) begin
      @(negedge clk);
      if ({tx_out[0], busy[0], in_ready[0]} !== 3'b110) bad = 1;
    end
    n_cmp++;
    if ({tmo, bad} !== 2'b00) begin
      n_err++;
      $display("FAIL stall_hold_arm: got timeout/bad=%b required 00", {tmo, bad});
    end
    tick_en = 1'b1;
    capture(0, 10, bits, tmo, uns, ed, rh);
    n_cmp++;
    if (bits !== {6'd0, 1'b1, 8'h81, 1'b0} || {tmo, uns, ed, rh} !== 4'b0 || done[0] !== 1'b1) begin
      n_err++;
      $display("FAIL stall_frame_81: got %h flags=%b done=%b required %h flags=0000 done=1",
               bits, {tmo, uns, ed, rh}, done[0], {6'd0, 1'b1, 8'h81, 1'b0});
    end
  endtask

  initial begin
    rst = 1'b1;
    tick_en = 1'b0;
    in_valid = 4'h0;
    for (int i = 0; i < 4; i++) in_data[i] = 8'h00;
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_two_stop();
    test_tick_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
